// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with a per-register busy
// scoreboard for RAW hazard detection in the decode stage.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   raddra_i, raddrb_i    read addresses (ports A and B)
//   douta_o, doutb_o      combinational read data
//   busya_o, busyb_o      combinational "register has an outstanding producer"
//   issue_i, issue_addr_i destination of the instruction issued this cycle
//   wen_i, waddr_i,       NWB write-back ports, packed; port k uses
//   wdata_i                 waddr_i[k*AW +: AW] and wdata_i[k*XLEN +: XLEN]
//   pend_cnt_o            registered number of busy registers
//
// Register 0 is hardwired zero: writes and issues to it are dropped, and it
// never reads busy. When several write ports target the same register the
// highest-index port wins, both for the stored value and for forwarding.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int NWB    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [AW-1:0]       raddra_i,
  input  logic [AW-1:0]       raddrb_i,
  output logic [XLEN-1:0]     douta_o,
  output logic [XLEN-1:0]     doutb_o,
  output logic                busya_o,
  output logic                busyb_o,
  input  logic                issue_i,
  input  logic [AW-1:0]       issue_addr_i,
  input  logic [NWB-1:0]      wen_i,
  input  logic [NWB*AW-1:0]   waddr_i,
  input  logic [NWB*XLEN-1:0] wdata_i,
  output logic [AW:0]         pend_cnt_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_q, cnt_d;

  // Returns {hit, data} for the highest-index write port targeting addr.
  function automatic logic [XLEN:0] fwd(input logic [AW-1:0] addr);
    logic [XLEN:0] res;
    res = '0;
    for (int k = 0; k < NWB; k++) begin
      if (wen_i[k] && (waddr_i[k*AW +: AW] == addr)) begin
        res = {1'b1, wdata_i[k*XLEN +: XLEN]};
      end
    end
    return res;
  endfunction

  // Next-state data, scoreboard and pending count.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    cnt_d  = '0;
    // Ascending port order lets the highest-index port overwrite earlier ones.
    for (int k = 0; k < NWB; k++) begin
      if (wen_i[k] && (waddr_i[k*AW +: AW] != '0)) begin
        regs_d[waddr_i[k*AW +: AW]] = wdata_i[k*XLEN +: XLEN];
        busy_d[waddr_i[k*AW +: AW]] = 1'b0;
      end
    end
    // Applied after the write-back clears so a new producer stays pending.
    if (issue_i && (issue_addr_i != '0)) begin
      busy_d[issue_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read ports: a same-cycle write-back is forwarded (BYPASS=1) and then the
  // reader no longer has to wait for it, so busy is masked too.
  logic [XLEN:0] fwd_a, fwd_b;
  logic          use_a, use_b;

  always_comb begin
    fwd_a = fwd(raddra_i);
    fwd_b = fwd(raddrb_i);
    use_a = (BYPASS != 0) && fwd_a[XLEN];
    use_b = (BYPASS != 0) && fwd_b[XLEN];

    if (raddra_i == '0)  douta_o = '0;
    else if (use_a)      douta_o = fwd_a[XLEN-1:0];
    else                 douta_o = regs_q[raddra_i];

    if (raddrb_i == '0)  doutb_o = '0;
    else if (use_b)      doutb_o = fwd_b[XLEN-1:0];
    else                 doutb_o = regs_q[raddrb_i];

    busya_o = busy_q[raddra_i] & ~use_a;
    busyb_o = busy_q[raddrb_i] & ~use_b;
  end

  assign pend_cnt_o = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed plus randomized bench for regfile_sb. Two instances
// share all inputs: u_byp (BYPASS=1) and u_nob (BYPASS=0). A behavioural
// model (data array, busy array) predicts every output.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NWB  = 2;

  logic                clk;
  logic                rst;
  logic [AW-1:0]       raddra, raddrb, issue_addr;
  logic                issue;
  logic [NWB-1:0]      wen;
  logic [NWB*AW-1:0]   waddr;
  logic [NWB*XLEN-1:0] wdata;
  logic [XLEN-1:0]     doa1, dob1, doa0, dob0;
  logic                ba1, bb1, ba0, bb0;
  logic [AW:0]         pc1, pc0;

  int checks = 0;
  int failures = 0;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NWB(NWB), .BYPASS(1)) u_byp (
    .clk_i(clk), .rst_i(rst), .raddra_i(raddra), .raddrb_i(raddrb),
    .douta_o(doa1), .doutb_o(dob1), .busya_o(ba1), .busyb_o(bb1),
    .issue_i(issue), .issue_addr_i(issue_addr), .wen_i(wen),
    .waddr_i(waddr), .wdata_i(wdata), .pend_cnt_o(pc1));

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NWB(NWB), .BYPASS(0)) u_nob (
    .clk_i(clk), .rst_i(rst), .raddra_i(raddra), .raddrb_i(raddrb),
    .douta_o(doa0), .doutb_o(dob0), .busya_o(ba0), .busyb_o(bb0),
    .issue_i(issue), .issue_addr_i(issue_addr), .wen_i(wen),
    .waddr_i(waddr), .wdata_i(wdata), .pend_cnt_o(pc0));

  // ---------------- reference model ----------------
  logic [XLEN-1:0] m_mem [NREG];
  bit              m_busy [NREG];
  bit              m_valid = 1'b0;

  function automatic logic [XLEN-1:0] m_read(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp) begin
      for (int k = NWB - 1; k >= 0; k--) begin
        if (wen[k] && int'(waddr[k*AW +: AW]) == a) return wdata[k*XLEN +: XLEN];
      end
    end
    return m_mem[a];
  endfunction

  function automatic logic m_busy_out(input int a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp) begin
      for (int k = 0; k < NWB; k++) begin
        if (wen[k] && int'(waddr[k*AW +: AW]) == a) return 1'b0;
      end
    end
    return m_busy[a];
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int r = 1; r < NREG; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  // Applies one clock edge worth of architectural rules to the model.
  task automatic m_edge();
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_mem[r] = '0;
        m_busy[r] = 1'b0;
      end
      m_valid = 1'b1;
    end else begin
      for (int k = 0; k < NWB; k++) begin
        int a;
        a = int'(waddr[k*AW +: AW]);
        if (wen[k] && a != 0) begin
          m_mem[a] = wdata[k*XLEN +: XLEN];
          m_busy[a] = 1'b0;
        end
      end
      if (issue && issue_addr != '0) m_busy[int'(issue_addr)] = 1'b1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb();
    if (m_valid) begin
      chk("douta_byp", doa1, m_read(int'(raddra), 1'b1));
      chk("doutb_byp", dob1, m_read(int'(raddrb), 1'b1));
      chk("douta_nob", doa0, m_read(int'(raddra), 1'b0));
      chk("doutb_nob", dob0, m_read(int'(raddrb), 1'b0));
      chk("busya_byp", 32'(ba1), 32'(m_busy_out(int'(raddra), 1'b1)));
      chk("busyb_byp", 32'(bb1), 32'(m_busy_out(int'(raddrb), 1'b1)));
      chk("busya_nob", 32'(ba0), 32'(m_busy_out(int'(raddra), 1'b0)));
      chk("busyb_nob", 32'(bb0), 32'(m_busy_out(int'(raddrb), 1'b0)));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rst = 1'b0;
    issue = 1'b0;
    issue_addr = '0;
    wen = '0;
    waddr = '0;
    wdata = '0;
  endtask

  task automatic wr(input int k, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wen[k] = 1'b1;
    waddr[k*AW +: AW] = a;
    wdata[k*XLEN +: XLEN] = d;
  endtask

  task automatic iss(input logic [AW-1:0] a);
    issue = 1'b1;
    issue_addr = a;
  endtask

  // One cycle: check combinational outputs, clock, update model, check count.
  task automatic cyc();
    #1;
    chk_comb();
    @(posedge clk);
    m_edge();
    #1;
    chk("pend_byp", 32'(pc1), 32'(m_count()));
    chk("pend_nob", 32'(pc0), 32'(m_count()));
    idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [XLEN-1:0] old7;
    int pc_before;
    idle();
    raddra = '0;
    raddrb = '0;
    @(posedge clk);
    #1;

    // Reset then sweep all addresses.
    rst = 1'b1;
    wr(0, 5'd6, 32'hFFFF_FFFF);
    iss(5'd6);
    cyc();
    chk("pend_after_reset", 32'(pc1), 32'd0);
    for (int a = 0; a < NREG; a++) begin
      raddra = AW'(a);
      raddrb = AW'(NREG - 1 - a);
      cyc();
    end

    // Write x5, x0 ignored.
    wr(0, 5'd5, 32'hDEAD_BEEF);
    raddra = 5'd5;
    cyc();
    #1;
    chk("x5_readback", doa0, 32'hDEAD_BEEF);
    wr(0, 5'd0, 32'h0000_1234);
    raddrb = 5'd0;
    cyc();
    #1;
    chk("x0_zero", dob1, 32'h0);

    // Port conflict with bypass.
    raddra = 5'd7;
    old7 = m_mem[7];
    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    #1;
    chk("x7_bypass_same_cycle", doa1, 32'h22);
    chk("x7_nobypass_old", doa0, old7);
    cyc();
    #1;
    chk("x7_next_byp", doa1, 32'h22);
    chk("x7_next_nob", doa0, 32'h22);

    // Scoreboard issue / write-back.
    iss(5'd3);
    raddra = 5'd3;
    cyc();
    #1;
    chk("x3_busy", 32'(ba1), 32'd1);
    chk("x3_pend", 32'(pc1), 32'd1);
    wr(0, 5'd3, 32'h55);
    #1;
    chk("x3_wb_busy_byp", 32'(ba1), 32'd0);
    chk("x3_wb_busy_nob", 32'(ba0), 32'd1);
    chk("x3_wb_data", doa1, 32'h55);
    cyc();
    chk("x3_pend_clear", 32'(pc1), 32'd0);

    // Simultaneous issue and write-back to busy x9.
    iss(5'd9);
    cyc();
    pc_before = int'(pc1);
    iss(5'd9);
    wr(1, 5'd9, 32'h99);
    raddra = 5'd9;
    cyc();
    #1;
    chk("x9_data", doa0, 32'h99);
    chk("x9_still_busy", 32'(ba1), 32'd1);
    chk("x9_pend_same", 32'(pc1), 32'(pc_before));
    wr(0, 5'd9, 32'h9A);
    cyc();

    // Reset mid-operation.
    iss(5'd1); cyc();
    iss(5'd2); cyc();
    iss(5'd4); cyc();
    chk("pend_three", 32'(pc1), 32'd3);
    rst = 1'b1;
    wr(0, 5'd2, 32'hABCD);
    cyc();
    raddra = 5'd2;
    raddrb = 5'd4;
    #1;
    chk("x2_after_reset", doa1, 32'h0);
    chk("x4_busy_after_reset", 32'(bb1), 32'd0);
    chk("pend_zero_after_reset", 32'(pc1), 32'd0);

    // Randomized traffic over a small address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 1) == 1) iss(AW'($urandom_range(0, 7)));
      for (int k = 0; k < NWB; k++) begin
        if ($urandom_range(0, 2) != 0) wr(k, AW'($urandom_range(0, 7)), $urandom);
      end
      raddra = AW'($urandom_range(0, 7));
      raddrb = AW'($urandom_range(0, 7));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the pipelined RISC-V core, replacing the fixed 32x32, 1-write/2-read file.
- Adds configurable width and depth, NWB write-back ports, and optional write-to-read bypass.
- Adds a per-register busy scoreboard (set at issue, cleared at write-back) so decode can detect RAW hazards.
- Sits between decode (read, issue) and the write-back stage(s).

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of two, >= 2); register 0 is hardwired zero
AW, $clog2(NREG), address width (derived; do not override)
NWB, 2, number of write-back ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous active-high reset
raddra_i  in  AW  read port A address
raddrb_i  in  AW  read port B address
douta_o  out  XLEN  read data A (combinational)
doutb_o  out  XLEN  read data B (combinational)
busya_o  out  1  register at raddra_i has an outstanding producer (combinational)
busyb_o  out  1  same for raddrb_i
issue_i  in  1  an instruction writing issue_addr_i is issued this cycle
issue_addr_i  in  AW  destination of issued instruction
wen_i  in  NWB  per-port write enable
waddr_i  in  NWB*AW  packed write addresses; port k occupies [k*AW +: AW]
wdata_i  in  NWB*XLEN  packed write data; port k occupies [k*XLEN +: XLEN]
pend_cnt_o  out  AW+1  number of registers currently marked busy (registered)

Behaviour:
- Reset (rst_i high at clock edge):
  - All NREG data registers and all busy bits clear to 0; pend_cnt_o = 0 the following cycle.
  - Reset overrides any same-cycle write or issue.
- Register 0:
  - Reads always return 0; busy always reads 0.
  - Writes and issues to address 0 are ignored; they never change pend_cnt_o.
- Write:
  - Port k commits wdata_k to reg[waddr_k] at the clock edge when wen_k=1 and waddr_k!=0.
  - Several ports with the same address in one cycle: the highest-index port wins.
  - Write latency is 1 cycle: a read in the next cycle returns the new value regardless of BYPASS.
- Read: douta_o/doutb_o are combinational, zero cycles from address.
  - BYPASS=1: if any port k has wen_k=1, waddr_k==raddr and raddr!=0, output wdata_k (highest-index matching port wins); otherwise reg[raddr].
  - BYPASS=0: always reg[raddr] (pre-edge value).
- Scoreboard, busy[r] next state, evaluated per register r!=0:
  - issue_i and issue_addr_i==r: busy <= 1. Issue takes priority over a same-cycle write-back, so the new producer remains pending.
  - Otherwise, any wen_k with waddr_k==r: busy <= 0.
  - Otherwise hold.
  - Write-back to a non-busy register is legal, applies data and leaves busy at 0.
- Busy outputs:
  - busya_o = busy[raddra_i] when no write-back to that register is in flight this cycle.
  - With BYPASS=1, a same-cycle write-back to raddra_i forces busya_o=0, because the data is forwarded.
  - With BYPASS=0, busya_o = busy[raddra_i].
  - A same-cycle issue to raddra_i does not affect busya_o (reader precedes issuer).
  - busyb_o follows the same rules for port B.
- pend_cnt_o:
  - Registered population count of busy[NREG-1:1], updated every edge from the next-state busy vector.
  - Range 0..NREG-1, cannot overflow AW+1 bits.

Test Plan:
- Reset then read: rst_i=1 one cycle, read addresses 0..31 -> all douta_o/doutb_o = 0, busy 0, pend_cnt_o = 0.
- Write/read and x0: port0 writes 0xDEADBEEF to x5, next cycle read x5 -> 0xDEADBEEF; write 0x1234 to x0 -> x0 reads 0.
- Bypass and port conflict (BYPASS=1): same cycle port0 writes 0x11 to x7 and port1 writes 0x22 to x7 while raddra_i=7 -> douta_o = 0x22 same cycle; next cycle x7 reads 0x22. With BYPASS=0, the same-cycle read returns the old value.
- Scoreboard: issue x3 -> next cycle busya_o=1 (raddra=3), pend_cnt_o=1; write-back x3=0x55 -> same cycle busya_o=0 and douta_o=0x55 (BYPASS=1); next cycle pend_cnt_o=0.
- Simultaneous issue and write-back to x9 (busy=1 beforehand) -> x9 data updated, busy[9] stays 1, pend_cnt_o unchanged.
- Reset mid-operation: issue x1, x2, x4 (pend_cnt_o=3), then assert rst_i together with a write to x2 -> next cycle all busy 0, x2 reads 0, pend_cnt_o = 0.
